// File: rtl/debounce_edge_det.sv
// debounce_edge_det
// Cleans up a raw asynchronous input (button/switch) so the downstream flop
// only ever sees a glitch-free level. Two-flop synchronizer, then a stability
// counter that accepts a new level only after it has differed from the current
// output for STABLE_CYCLES consecutive cycles. Also produces registered
// rise/fall pulses and a wrapping count of accepted rising edges.
module debounce_edge_det #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  output logic             dout,
  output logic             dout_n,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_count,
  output logic             busy
);

  // Counter only needs to reach STABLE_CYCLES-1; a single cycle still needs 1 bit.
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;

  // Two-flop synchronizer; runs regardless of enable so s2 is always current.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Decide the next count and whether the candidate level is accepted this cycle.
  always_comb begin
    cnt_next = '0;
    accept   = 1'b0;
    if (!en) begin
      cnt_next = '0;
    end else if (s2 == dout) begin
      cnt_next = '0;
    end else if (cnt == LAST) begin
      accept   = 1'b1;
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Debounced level, one-cycle pulses and rising-edge counter; reset beats any pending change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      dout       <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      edge_count <= '0;
    end else begin
      cnt  <= cnt_next;
      rise <= accept & s2;
      fall <= accept & ~s2;
      if (accept) begin
        dout <= s2;
      end
      if (accept && s2) begin
        edge_count <= edge_count + 1'b1;
      end
    end
  end

  assign dout_n = ~dout;
  assign busy   = (cnt != '0);

endmodule

// File: tb/tb_debounce_edge_det.sv
// tb_debounce_edge_det
// Directed bench for debounce_edge_det with STABLE_CYCLES=4, CNT_W=8.
// Each step drives inputs, queues the outputs expected after the next rising
// edge, then pops and compares them 1 ns after that edge.
`timescale 1ns/1ps
module tb_debounce_edge_det;

  logic       clk;
  logic       reset;
  logic       din;
  logic       en;
  logic       dout;
  logic       dout_n;
  logic       rise;
  logic       fall;
  logic [7:0] edge_count;
  logic       busy;

  typedef struct {
    string      tag;
    logic       dout;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] edge_count;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         errors;
  logic       exp_level;
  logic [7:0] exp_count;

  debounce_edge_det #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .en         (en),
    .dout       (dout),
    .dout_n     (dout_n),
    .rise       (rise),
    .fall       (fall),
    .edge_count (edge_count),
    .busy       (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout simulation did not finish got running want finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic compare(input string tag, input string what, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s %s got %0h want %0h", tag, what, got, want);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard empty got 0 entries want 1");
      return;
    end
    e = sb.pop_front();
    compare(e.tag, "dout", {7'd0, dout}, {7'd0, e.dout});
    compare(e.tag, "dout_n", {7'd0, dout_n}, {7'd0, ~e.dout});
    compare(e.tag, "rise", {7'd0, rise}, {7'd0, e.rise});
    compare(e.tag, "fall", {7'd0, fall}, {7'd0, e.fall});
    compare(e.tag, "busy", {7'd0, busy}, {7'd0, e.busy});
    compare(e.tag, "edge_count", edge_count, e.edge_count);
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, clock and check.
  task automatic applyStimulus(input logic d, input logic e, input logic r,
                               input logic x_dout, input logic x_rise, input logic x_fall,
                               input logic x_busy, input logic [7:0] x_cnt, input string tag);
    exp_t x;
    din   = d;
    en    = e;
    reset = r;
    x.tag        = tag;
    x.dout       = x_dout;
    x.rise       = x_rise;
    x.fall       = x_fall;
    x.busy       = x_busy;
    x.edge_count = x_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Quiet cycles: no pending change, no pulses.
  task automatic idle(input int n, input logic d, input logic e, input string tag);
    for (int i = 0; i < n; i++)
      applyStimulus(d, e, 1'b0, exp_level, 1'b0, 1'b0, 1'b0, exp_count, tag);
  endtask

  // Clean held change to level d: two synchronizer edges, three counting edges,
  // the accepting edge with its pulse, then one edge with the pulse gone.
  task automatic accept_level(input logic d, input string tag);
    logic old;
    old = exp_level;
    applyStimulus(d, 1'b1, 1'b0, old, 1'b0, 1'b0, 1'b0, exp_count, tag);
    applyStimulus(d, 1'b1, 1'b0, old, 1'b0, 1'b0, 1'b0, exp_count, tag);
    for (int i = 0; i < 3; i++)
      applyStimulus(d, 1'b1, 1'b0, old, 1'b0, 1'b0, 1'b1, exp_count, tag);
    if (d) exp_count = exp_count + 8'd1;
    exp_level = d;
    applyStimulus(d, 1'b1, 1'b0, d, d, ~d, 1'b0, exp_count, tag);
    applyStimulus(d, 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, exp_count, tag);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_level = 1'b0;
    exp_count = 8'd0;
    din       = 1'b1;
    en        = 1'b1;
    reset     = 1'b1;

    // Reset with din high: everything stays at reset values.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "reset");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "reset");
    idle(3, 1'b0, 1'b1, "post_reset");

    // Clean rise.
    accept_level(1'b1, "clean_rise");
    idle(2, 1'b1, 1'b1, "hold_high");

    // Back low, then glitches of 2 and 3 cycles are rejected.
    accept_level(1'b0, "back_low");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "glitch2");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "glitch2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "glitch2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "glitch2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "glitch2");
    idle(2, 1'b0, 1'b1, "glitch2_after");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "glitch3");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "glitch3");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "glitch3");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "glitch3");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "glitch3");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "glitch3");
    idle(2, 1'b0, 1'b1, "glitch3_after");

    // Rise, then a held fall: single fall pulse, edge_count unchanged.
    accept_level(1'b1, "rise2");
    accept_level(1'b0, "fall");
    idle(2, 1'b0, 1'b1, "hold_low");

    // Enable dropped at count 2 discards progress; re-enable needs 4 more edges.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "en_drop");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "en_drop");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "en_drop");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "en_drop");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "en_low");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "en_low");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count, "en_low");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "re_en");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "re_en");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_count, "re_en");
    exp_count = exp_count + 8'd1;
    exp_level = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, exp_count, "re_en_rise");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_count, "re_en_after");

    // Pending fall reaches count 3, then reset lands on the completing edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_count, "rst_mid");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_count, "rst_mid");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_count, "rst_mid");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_count, "rst_mid");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, exp_count, "rst_mid");
    exp_count = 8'd0;
    exp_level = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "rst_wins");
    idle(3, 1'b0, 1'b1, "rst_after");

    // 256 accepted rising edges: count climbs to 255 then wraps to 0.
    for (int k = 1; k <= 256; k++) begin
      accept_level(1'b1, "wrap_rise");
      if (k == 255) compare("wrap_255", "edge_count", edge_count, 8'd255);
      if (k == 256) compare("wrap_0", "edge_count", edge_count, 8'd0);
      accept_level(1'b0, "wrap_fall");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
